// File: rtl/pong_match_fsm.sv
// Match sequencer for pong: serve delay, rally, point pause, game over, scoring and winner.
// Optional PONG_WIN_BY_TWO_EN: win needs a two-point lead (with a saturation guard at all-ones).
module pong_match_fsm #(
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 11,
  parameter int X_W         = 11,
  parameter int LEFT_LIMIT  = 8,
  parameter int RIGHT_LIMIT = 1016,
  parameter int SERVE_TICKS = 60,
  parameter int POINT_TICKS = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               timing_tick,
  input  logic               start,
  input  logic [X_W-1:0]     x_ball,
  output logic               ball_run,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] player1_score,
  output logic [SCORE_W-1:0] player2_score,
  output logic [1:0]         point_evt,
  output logic [1:0]         winner,
  output logic [2:0]         state
);

  localparam int MAX_TICKS = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SERVE     = 3'd1,
    S_RALLY     = 3'd2,
    S_POINT     = 3'd3,
    S_GAME_OVER = 3'd4
  } st_t;

  st_t                fsm;
  logic [CNT_W-1:0]   cnt;
  logic               start_q;
  logic               armed;
  logic               start_edge;
  logic [SCORE_W-1:0] p1_next;
  logic [SCORE_W-1:0] p2_next;

  assign state   = fsm;
  assign p1_next = player1_score + 1'b1;
  assign p2_next = player2_score + 1'b1;

  function automatic logic wins(input logic [SCORE_W-1:0] mine, input logic [SCORE_W-1:0] opp);
`ifdef PONG_WIN_BY_TWO_EN
    logic [SCORE_W:0] m;
    logic [SCORE_W:0] o2;
    m  = {1'b0, mine};
    o2 = {1'b0, opp} + (SCORE_W+1)'(2);
    return (mine == '1) || ((m >= (SCORE_W+1)'(WIN_SCORE)) && (m >= o2));
`else
    logic unused;
    unused = ^opp;
    return mine == SCORE_W'(WIN_SCORE);
`endif
  endfunction

  // armed stays low for the first edge after reset so a start held through reset never looks like a rising edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      start_q    <= 1'b0;
      armed      <= 1'b0;
      start_edge <= 1'b0;
    end else begin
      start_q    <= start;
      armed      <= 1'b1;
      start_edge <= start & ~start_q & armed;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm           <= S_IDLE;
      cnt           <= '0;
      ball_run      <= 1'b0;
      ball_reset    <= 1'b0;
      serve_dir     <= 1'b1;
      player1_score <= '0;
      player2_score <= '0;
      point_evt     <= 2'b00;
      winner        <= 2'b00;
    end else begin
      ball_reset <= 1'b0;
      point_evt  <= 2'b00;
      case (fsm)
        S_IDLE, S_GAME_OVER: begin
          ball_run <= 1'b0;
          if (start_edge) begin
            fsm           <= S_SERVE;
            cnt           <= '0;
            ball_reset    <= 1'b1;
            serve_dir     <= 1'b1;
            player1_score <= '0;
            player2_score <= '0;
            winner        <= 2'b00;
          end
        end
        S_SERVE: begin
          if (timing_tick) begin
            if (cnt == CNT_W'(SERVE_TICKS - 1)) begin
              fsm      <= S_RALLY;
              cnt      <= '0;
              ball_run <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_RALLY: begin
          if (timing_tick) begin
            if (x_ball <= X_W'(LEFT_LIMIT)) begin
              fsm           <= S_POINT;
              cnt           <= '0;
              ball_run      <= 1'b0;
              player2_score <= p2_next;
              point_evt     <= 2'b10;
              serve_dir     <= 1'b0;
              if (wins(p2_next, player1_score)) winner <= 2'b10;
            end else if (x_ball >= X_W'(RIGHT_LIMIT)) begin
              fsm           <= S_POINT;
              cnt           <= '0;
              ball_run      <= 1'b0;
              player1_score <= p1_next;
              point_evt     <= 2'b01;
              serve_dir     <= 1'b1;
              if (wins(p1_next, player2_score)) winner <= 2'b01;
            end
          end
        end
        S_POINT: begin
          if (timing_tick) begin
            if (cnt == CNT_W'(POINT_TICKS - 1)) begin
              cnt <= '0;
              if (winner != 2'b00) begin
                fsm <= S_GAME_OVER;
              end else begin
                fsm        <= S_SERVE;
                ball_reset <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          fsm      <= S_IDLE;
          cnt      <= '0;
          ball_run <= 1'b0;
        end
      endcase
    end
  end

endmodule
